// File: rtl/rv32_m_data_memory.sv
// Word-organised data memory with a valid/ready request/response handshake and a fixed extra latency.
// Optional macro RV32_DMEM_BOUNDS_CHECK_EN turns out-of-range accesses into error responses.
module rv32_m_data_memory #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_we_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_next;
  logic [3:0]        wait_cnt, wait_cnt_next;
  logic [IDX_W-1:0]  idx_q, acc_idx;
  logic [3:0]        we_q, acc_we;
  logic [31:0]       wdata_q, acc_wdata;
  logic [31:0]       rdata_q;
  logic              accept, commit, acc_oor;
  logic              unused_addr;
  logic [31:0]       mem [DEPTH_WORDS];

  assign req_ready_o = (state == IDLE) && rst_ni;
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = (state == RESP);
  assign rsp_rdata_o = rdata_q;

  // With zero wait cycles the access happens on the accept edge, so use the live request.
  assign acc_idx   = (state == IDLE) ? req_addr_i[IDX_W+1:2] : idx_q;
  assign acc_we    = (state == IDLE) ? req_we_i : we_q;
  assign acc_wdata = (state == IDLE) ? req_wdata_i : wdata_q;

`ifdef RV32_DMEM_BOUNDS_CHECK_EN
  logic oor_q, err_q;

  assign acc_oor     = (state == IDLE) ? (req_addr_i[31:IDX_W+2] != '0) : oor_q;
  assign rsp_err_o   = err_q;
  assign unused_addr = ^req_addr_i[1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept) oor_q <= acc_oor;
      if (commit) err_q <= acc_oor;
    end
  end
`else
  assign acc_oor     = 1'b0;
  assign rsp_err_o   = 1'b0;
  assign unused_addr = ^{req_addr_i[31:IDX_W+2], req_addr_i[1:0]};
`endif

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    commit        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next    = WAIT;
            wait_cnt_next = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt <= 4'd1) begin
          state_next    = RESP;
          wait_cnt_next = 4'd0;
          commit        = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      idx_q    <= '0;
      we_q     <= 4'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (accept) begin
        idx_q   <= acc_idx;
        we_q    <= acc_we;
        wdata_q <= acc_wdata;
      end
      // Read-before-write: the response carries the word as it was before this commit.
      if (commit) rdata_q <= acc_oor ? 32'd0 : mem[acc_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && commit && !acc_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_we[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/rv32_m_data_memory.md
RV32_M_DATA_MEMORY -- requirements
Module: rv32_m_data_memory

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words; SHALL be a power of two.
REQ-002 Parameter WAIT_CYCLES, default 1: extra access latency in cycles; SHALL allow any value 0..15.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  input  1  reset, synchronous and active-low.
REQ-005 req_valid_i  input  1  request present.
REQ-006 req_ready_o  output  1  block can accept a request.
REQ-007 req_addr_i  input  32  byte address; bits [1:0] SHALL be ignored because lane alignment is done upstream.
REQ-008 req_we_i  input  4  per-byte write enables; 4'b0000 means a read.
REQ-009 req_wdata_i  input  32  lane-aligned write data.
REQ-010 rsp_valid_o  output  1  response present.
REQ-011 rsp_ready_i  input  1  consumer accepts the response.
REQ-012 rsp_rdata_o  output  32  full word read from memory, not lane-shifted.
REQ-013 rsp_err_o  output  1  out-of-range access flag; only active when the REQ-026 macro is defined.

Function
REQ-014 FSM states SHALL be IDLE, WAIT and RESP; req_ready_o SHALL be 1 only in IDLE with rst_ni high.
REQ-015 Accept SHALL occur when req_valid_i and req_ready_o are both 1; addr, we and wdata SHALL be captured on that edge.
REQ-016 Word index SHALL be captured addr bits [log2(DEPTH_WORDS)+1:2].
REQ-017 State transitions:
- On accept, IDLE SHALL go to WAIT if WAIT_CYCLES>0, else to RESP.
- WAIT SHALL count down from WAIT_CYCLES and go to RESP on the edge where the count reaches zero.
- RESP SHALL go to IDLE on the rsp_valid_o and rsp_ready_i handshake.
REQ-018 The memory access SHALL happen on the edge entering RESP.
- Bytes with a set we bit SHALL be written.
- rsp_rdata_o SHALL load the word contents from before that write (read-before-write).
REQ-019 Latency: for an accept at edge N, rsp_valid_o SHALL be 1 from edge N+1+WAIT_CYCLES.
REQ-020 rsp_valid_o SHALL be 1 exactly in RESP; rsp_rdata_o and rsp_err_o SHALL stay stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-021 No new request SHALL be accepted in the cycle of a response handshake; peak throughput SHALL be one transaction per WAIT_CYCLES+2 cycles.
REQ-022 req_valid_i outside IDLE SHALL be ignored; the requester SHALL hold it until accepted.

Reset
REQ-023 While rst_ni=0 at an edge, the following SHALL apply:
- state SHALL go to IDLE and the wait counter to 0;
- rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL be 0;
- req_ready_o SHALL be 0 during reset and 1 in the first cycle after reset.
REQ-024 Memory array contents SHALL NOT be reset.
REQ-025 Reset in WAIT SHALL drop the pending transaction; a write not yet committed SHALL NOT modify memory.

Configuration
REQ-026 Macro RV32_DMEM_BOUNDS_CHECK_EN controls out-of-range handling.
- Defined: a captured byte address at or above 4*DEPTH_WORDS SHALL perform no write and SHALL return rsp_rdata_o=0 and rsp_err_o=1.
- Not defined: high address bits SHALL be ignored, so the index wraps modulo DEPTH_WORDS, and rsp_err_o SHALL be tied 0.

Verification
REQ-027 Full-word write (DEPTH 1024, WAIT 1): write 0xDEADBEEF to 0x10 with we=4'hF, then read 0x10 -> rdata 0xDEADBEEF; rsp_valid_o 2 cycles after accept; the write response returns the prior word.
REQ-028 Byte write: after REQ-027, write wdata 0x00AB0000 with we=4'b0100 to 0x12, then read 0x10 -> 0xDEABBEEF.
REQ-029 Backpressure: hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o=1 and rdata constant, req_ready_o=0; handshake on cycle 6, then IDLE.
REQ-030 Reset mid-write: write 0x12345678 to 0x20 (previously 0) and pulse rst_ni=0 during WAIT -> a subsequent read of 0x20 returns 0.
REQ-031 Out of range: write 0xCAFEF00D to 0x1000, then read 0x0.
- Macro defined: rsp_err_o=1, rdata 0, and word 0 unchanged.
- Macro undefined: the write aliases to word 0, and the read returns 0xCAFEF00D.
REQ-032 WAIT_CYCLES=0: read accepted at edge N -> rsp_valid_o=1 at edge N+1; back-to-back reads spaced 2 cycles apart.
